fetch_queue: RTL and testbench

//   Parametrised decoupling buffer between the PC/fetch stage and decode.
//   - Stores fetched {pc, instr} entries in a circular FIFO.
//   - Lets fetch run ahead while decode stalls on hazards.
//   - Discards all in-flight entries on a redirect (branch/jump flush).
//   - Replaces the single fetch->decode register with DEPTH entries and valid/ready handshakes on both sides.

---
 rtl/fetch_queue_pkg.sv | 14 +
 rtl/fetch_queue_mem.sv | 28 ++
 rtl/fetch_queue.sv | 124 ++++++++++++
 tb/tb_fetch_queue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and sizes for the fetch->decode queue.
package fetch_queue_pkg;

  localparam int unsigned FQ_XLEN           = 32;
  localparam int unsigned FQ_ILEN           = 32;
  localparam int unsigned FETCH_QUEUE_DEPTH = 4;

  // One fetched instruction with its program counter
  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_ILEN-1:0] instr;
  } fetch_entry_t;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: one synchronous write port, one
// asynchronous read port, no reset on the array.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = FETCH_QUEUE_DEPTH,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  fetch_entry_t     wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output fetch_entry_t     rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  // Write the pushed entry into its slot
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fetch_queue_mem

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode with flush on redirect.
// Optional macro FETCH_QUEUE_BYPASS_EN: an entry offered to an empty queue
// while decode is ready passes straight through in the same cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned XLEN  = FQ_XLEN,
  parameter int unsigned ILEN  = FQ_ILEN,
  parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [ILEN-1:0]        in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [ILEN-1:0]        out_instr,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] level_q, level_d;
  fetch_entry_t     last_q, last_d;
  fetch_entry_t     head;
  fetch_entry_t     wdata;
  fetch_entry_t     out_entry;
  logic             empty;
  logic             full;
  logic             bypass;
  logic             push;
  logic             pop;

  fetch_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[IDX_W-1:0]),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q[IDX_W-1:0]),
    .rdata_o (head)
  );

  // Status flags, handshakes and output data selection
  always_comb begin
    empty = (rd_ptr_q == wr_ptr_q);
    full  = (rd_ptr_q[PTR_W-1] != wr_ptr_q[PTR_W-1]) &&
            (rd_ptr_q[IDX_W-1:0] == wr_ptr_q[IDX_W-1:0]);
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = empty & in_valid & out_ready & ~flush & rst;
`else
    bypass = 1'b0;
`endif
    in_ready  = ~full & ~flush & rst;
    out_valid = (~empty & ~flush) | bypass;
    // A bypassed entry is consumed directly and never written
    push = in_valid & in_ready & ~bypass;
    pop  = ~empty & ~flush & out_ready;

    wdata.pc    = FQ_XLEN'(in_pc);
    wdata.instr = FQ_ILEN'(in_instr);

    // When nothing is queued, keep presenting the last entry handed to decode
    out_entry = empty ? last_q : head;
    if (bypass) begin
      out_entry = wdata;
    end
    out_pc    = XLEN'(out_entry.pc);
    out_instr = ILEN'(out_entry.instr);
    level     = level_q;
  end

  // Pointer, occupancy and last-read updates
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    last_d   = last_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        last_d   = head;
      end
      if (bypass) begin
        last_d = wdata;
      end
      unique case ({push, pop})
        2'b10:   level_d = level_q + PTR_W'(1);
        2'b01:   level_d = level_q - PTR_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
    end
  end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default DEPTH=4).
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  level;

  int n_cmp;
  int n_err;

  fetch_queue dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hC0DE_0000 ^ pc;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = instr_of(pc);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    offer(1'b1, 32'h1000);

    // 1: reset held three cycles with fetch offering
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_level", 32'(level), 32'd0);
      check_eq("rst_out_pc", out_pc, 32'd0);
      cyc();
    end
    rst = 1'b1;
    #1;
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
    cyc();
    offer(1'b0, 32'h0);
    #1;
    check_eq("first_push_level", 32'(level), 32'd1);
    check_eq("first_push_pc", out_pc, 32'h1000);
    check_eq("first_push_instr", out_instr, instr_of(32'h1000));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    #1;
    check_eq("first_drain_level", 32'(level), 32'd0);

    // 2: fill to full, then drain in order
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'(i * 4));
      #1;
      check_eq("fill_in_ready", 32'(in_ready), 32'd1);
      cyc();
    end
    offer(1'b1, 32'h10);
    #1;
    check_eq("full_level", 32'(level), 32'd4);
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    offer(1'b0, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("drain_valid", 32'(out_valid), 32'd1);
      check_eq("drain_pc", out_pc, 32'(i * 4));
      check_eq("drain_instr", out_instr, instr_of(32'(i * 4)));
      cyc();
    end
    #1;
    check_eq("drained_valid", 32'(out_valid), 32'd0);
    check_eq("drained_level", 32'(level), 32'd0);

    // 3: steady stream, pointers wrap several times
    for (int k = 0; k < 20; k++) begin
      offer(1'b1, 32'h300 + 32'(k * 4));
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      check_eq("stream_valid", 32'(out_valid), 32'd1);
      check_eq("stream_pc", out_pc, 32'h300 + 32'(k * 4));
      check_eq("stream_level", 32'(level), 32'd0);
`else
      if (k == 0) begin
        check_eq("stream_first_valid", 32'(out_valid), 32'd0);
      end else begin
        check_eq("stream_valid", 32'(out_valid), 32'd1);
        check_eq("stream_pc", out_pc, 32'h300 + 32'((k - 1) * 4));
        check_eq("stream_level", 32'(level), 32'd1);
      end
`endif
      cyc();
    end
    offer(1'b0, 32'h0);
`ifndef FETCH_QUEUE_BYPASS_EN
    #1;
    check_eq("stream_tail_pc", out_pc, 32'h300 + 32'(19 * 4));
    cyc();
`endif
    #1;
    check_eq("stream_end_valid", 32'(out_valid), 32'd0);
    check_eq("stream_end_level", 32'(level), 32'd0);

    // 4: full with simultaneous pop refuses the push
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'h500 + 32'(i * 4));
      cyc();
    end
    offer(1'b1, 32'h510);
    out_ready = 1'b1;
    #1;
    check_eq("fullpop_in_ready", 32'(in_ready), 32'd0);
    check_eq("fullpop_pc", out_pc, 32'h500);
    cyc();
    offer(1'b0, 32'h0);
    out_ready = 1'b0;
    #1;
    check_eq("fullpop_level", 32'(level), 32'd3);
    check_eq("fullpop_next_pc", out_pc, 32'h504);

    // 5: flush drops everything and suppresses the same-cycle transfer
    flush     = 1'b1;
    out_ready = 1'b1;
    offer(1'b1, 32'h100);
    #1;
    check_eq("flush_out_valid", 32'(out_valid), 32'd0);
    check_eq("flush_in_ready", 32'(in_ready), 32'd0);
    cyc();
    flush     = 1'b0;
    out_ready = 1'b0;
    offer(1'b0, 32'h0);
    #1;
    check_eq("flush_level", 32'(level), 32'd0);
    check_eq("flush_empty", 32'(out_valid), 32'd0);
    offer(1'b1, 32'h200);
    cyc();
    offer(1'b0, 32'h0);
    #1;
    check_eq("post_flush_pc", out_pc, 32'h200);
    check_eq("post_flush_level", 32'(level), 32'd1);
    out_ready = 1'b1;
    cyc();
    #1;
    check_eq("post_flush_drain", 32'(level), 32'd0);

    // 6: empty queue, both sides ready
    offer(1'b1, 32'h40);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check_eq("bypass_valid", 32'(out_valid), 32'd1);
    check_eq("bypass_pc", out_pc, 32'h40);
    check_eq("bypass_level", 32'(level), 32'd0);
    cyc();
    offer(1'b0, 32'h0);
    #1;
    check_eq("bypass_after_valid", 32'(out_valid), 32'd0);
    check_eq("bypass_after_level", 32'(level), 32'd0);
`else
    check_eq("nobypass_valid", 32'(out_valid), 32'd0);
    cyc();
    offer(1'b0, 32'h0);
    #1;
    check_eq("nobypass_next_valid", 32'(out_valid), 32'd1);
    check_eq("nobypass_next_pc", out_pc, 32'h40);
    cyc();
    #1;
    check_eq("nobypass_drain", 32'(level), 32'd0);
`endif

    // 7: reset asserted mid-cycle while holding entries
    out_ready = 1'b0;
    offer(1'b1, 32'h600);
    cyc();
    offer(1'b1, 32'h604);
    cyc();
    offer(1'b1, 32'h700);
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_level", 32'(level), 32'd0);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
    check_eq("midrst_out_pc", out_pc, 32'd0);
    cyc();
    offer(1'b0, 32'h0);
    rst = 1'b1;
    cyc();
    #1;
    check_eq("midrst_after_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_after_level", 32'(level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_queue
